result_recorder: RTL
====================

# result_recorder

Writer-side counterpart of the preset reader in the systolic-array lab top. On a capture strobe it waits a fixed number of cycles for the systolic cell output to settle, then stores the cell result into a per-preset result memory. It compares the stored value against the expected value, keeps per-preset valid/pass flags, and offers a button-stepped readback port that feeds the seven-segment display.

## Interface
- `DATA_WIDTH`, 8, operand width; results are `2*DATA_WIDTH` bits.
- `PRESETS`, 8, number of preset slots (power of two, ≥2); index width `IDX_W = $clog2(PRESETS)`.
- `LATENCY`, 2, settle cycles between capture and sampling; must be ≥1.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `capture`  in  1  one-cycle strobe (debounced key); request to record the current preset.
- `code`  in  IDX_W  preset index being computed; latched on an accepted capture.
- `result_in`  in  2*DATA_WIDTH  systolic cell `out_data`.
- `expected`  in  2*DATA_WIDTH  reference result from the preset reader.
- `show`  in  1  one-cycle strobe; advances the readback index.
- `busy`  out  1  high while a capture is in flight.
- `rd_idx`  out  IDX_W  current readback slot.
- `rd_data`  out  2*DATA_WIDTH  registered content of slot `rd_idx`.
- `valid_mask`  out  PRESETS  bit i is set once slot i has been written.
- `pass_mask`  out  PRESETS  bit i is set when the last recorded result for slot i matched.
- `all_pass`  out  1  `&valid_mask & &pass_mask`, registered.

## Operation
- FSM states: IDLE, WAIT, WRITE.
- IDLE: `capture` = 1 latches `code` into `idx_q`, loads `cnt = LATENCY-1`, and moves to WAIT.
- WAIT: `cnt` decrements each cycle. At `cnt == 0` the FSM moves to WRITE, so WAIT lasts exactly LATENCY cycles.
- WRITE: samples `result_in` and `expected` in the same cycle. It writes `mem[idx_q] <= result_in`, sets `valid_mask[idx_q] <= 1`, sets `pass_mask[idx_q] <= (result_in == expected)`, then returns to IDLE.
- `capture` while in WAIT or WRITE is ignored and dropped, not queued.
- `code` changes after acceptance have no effect; the latched `idx_q` is used.
- Readback: `show` increments `rd_idx` modulo PRESETS, so PRESETS-1 wraps to 0. `rd_data <= mem[rd_idx_next]` every cycle.
- Simultaneous WRITE to slot k while `rd_idx` = k: `rd_data` shows the new value one cycle after WRITE (no bypass).
- Simultaneous `show` and `capture`: both are honoured independently.
- Comparison is the full `2*DATA_WIDTH`-bit equality; no signed interpretation.

## Timing
- Reset values: state IDLE, `busy` 0, `rd_idx` 0, `rd_data` 0, all `mem` slots 0, `valid_mask` 0, `pass_mask` 0, `all_pass` 0.
- Capture accepted at cycle t:
  - `busy` is 1 from t+1 through t+1+LATENCY, i.e. LATENCY+1 cycles.
  - The WRITE state occupies cycle t+1+LATENCY.
  - `mem`, `valid_mask` and `pass_mask` update at t+2+LATENCY.
  - `all_pass` updates at t+3+LATENCY.
- Earliest next accepted capture is at t+2+LATENCY.
- `show` at cycle t: `rd_idx` updates at t+1; `rd_data` reflects the new slot at t+1.
- Asserting `reset_n` low mid-capture aborts it immediately and asynchronously: the slot is not written and all state returns to reset values.

## Configuration
- `RESULT_RECORDER_STICKY_FAIL_EN` defined: a recorded mismatch is sticky. `pass_mask[i]` can only go 1→0 after the first write; a later matching capture stores the data but leaves the bit at 0. The first write to a slot sets the bit from its comparison.
- Not defined: each WRITE overwrites `pass_mask[i]` with the latest comparison.

## Structure
- Shared package `sys_array_pkg` holds:
  - the state enum `rec_state_t` (IDLE/WAIT/WRITE);
  - `localparam DATA_WIDTH_DEFAULT = 8`;
  - `typedef logic [2*DATA_WIDTH_DEFAULT-1:0] result_t`.
- No sub-module: a single FSM, a down-counter, a register-array memory and a readback pointer all sit in one module. Memory is flops, not inferred BRAM, so it can be reset.

## Test plan
- Reset, then idle 10 cycles → every output is 0 and `busy` stays 0.
- `code`=3, `result_in`=16'h0A0B, `expected`=16'h0A0B, pulse `capture`, LATENCY=2:
  - `busy` is high for 3 cycles;
  - `valid_mask`=8'h08 and `pass_mask`=8'h08 at t+4;
  - after 3 `show` pulses, `rd_idx`=3 and `rd_data`=16'h0A0B.
- Capture slot 5 with `result_in`=16'h0001, `expected`=16'h0002 → `pass_mask[5]`=0. Recapture slot 5 with matching values:
  - macro undefined → `pass_mask[5]`=1;
  - macro defined → `pass_mask[5]`=0, `mem[5]` updated.
- Second `capture` pulse at t+1 and at t+2 during WAIT → ignored: exactly one write occurs, no second `busy` window.
- Change `code` from 2 to 6 one cycle after acceptance → only slot 2 is written; `valid_mask`=8'h04.
- Capture all 8 slots with matching data → `all_pass`=1. Then:
  - 8 `show` pulses wrap `rd_idx` back to 0;
  - `reset_n` low during a later WAIT clears all masks and `mem[idx]` is not written.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array lab: result recorder state and result width.
// Used by result_recorder (optional RESULT_RECORDER_STICKY_FAIL_EN).
package sys_array_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef logic [2*DATA_WIDTH_DEFAULT-1:0] result_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } rec_state_t;

endpackage

// File: rtl/result_recorder.sv
// Records settled systolic results per preset, tracks valid/pass, offers readback.
// Define RESULT_RECORDER_STICKY_FAIL_EN to make a recorded mismatch sticky.
module result_recorder
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int PRESETS    = 8,
  parameter int LATENCY    = 2,
  localparam int IDX_W     = $clog2(PRESETS),
  localparam int RW        = 2*DATA_WIDTH
)(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             capture,
  input  logic [IDX_W-1:0] code,
  input  logic [RW-1:0]    result_in,
  input  logic [RW-1:0]    expected,
  input  logic             show,
  output logic             busy,
  output logic [IDX_W-1:0] rd_idx,
  output logic [RW-1:0]    rd_data,
  output logic [PRESETS-1:0] valid_mask,
  output logic [PRESETS-1:0] pass_mask,
  output logic             all_pass
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  rec_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_en;

  logic [RW-1:0]    mem_q [PRESETS];
  logic [IDX_W-1:0] rd_idx_d;
  logic             match;
  logic             pass_bit;

  assign busy  = (state_q != IDLE);
  assign match = (result_in == expected);

`ifdef RESULT_RECORDER_STICKY_FAIL_EN
  // once a slot has failed it stays failed until reset
  assign pass_bit = valid_mask[idx_q] ? (pass_mask[idx_q] & match)
                                      : match;
`else
  assign pass_bit = match;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          idx_d   = code;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PRESETS; i++) begin
        mem_q[i] <= '0;
      end
      valid_mask <= '0;
      pass_mask  <= '0;
    end else if (wr_en) begin
      mem_q[idx_q]      <= result_in;
      valid_mask[idx_q] <= 1'b1;
      pass_mask[idx_q]  <= pass_bit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      all_pass <= 1'b0;
    end else begin
      all_pass <= (&valid_mask) & (&pass_mask);
    end
  end

  // readback reads the pre-write memory: no bypass of a same-cycle write
  assign rd_idx_d = show ? rd_idx + IDX_W'(1) : rd_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx  <= '0;
      rd_data <= '0;
    end else begin
      rd_idx  <= rd_idx_d;
      rd_data <= mem_q[rd_idx_d];
    end
  end

endmodule
